ifmap_spad_fill_ctrl: RTL

Fill controller between the IFMap buffer (FIFO) and the IFMap scratchpad of a PE. On `start` it streams `row_len` words out of the buffer into the scratchpad, which it treats as a circular store of `IFMAP_SPAD_ROW` entries. The PE datapath frees consumed entries with `rel`/`rel_num`, and the controller accepts new words only into free slots. It owns the scratchpad write port and publishes the read base pointer for the read side.

---
 rtl/ifmap_spad_fill_ctrl_pkg.sv | 20 ++
 rtl/spad_ptr_wrap.sv | 46 ++++
 rtl/ifmap_spad_fill_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/ifmap_spad_fill_ctrl_pkg.sv
// Shared definitions for the IFMap scratchpad fill path: FSM encoding and the
// address/count width helpers used by the scratchpad and its read controller.
package ifmap_spad_fill_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } fill_state_t;

   function automatic int addr_width(input int rows);
      return (rows > 1) ? $clog2(rows) : 1;
   endfunction

   // One extra value so a completely full scratchpad can be counted.
   function automatic int cnt_width(input int rows);
      return $clog2(rows + 1);
   endfunction

endpackage

// File: rtl/spad_ptr_wrap.sv
// Modulo-ROW pointer that advances by a variable amount, with an optional
// direct load that takes priority over the advance.
module spad_ptr_wrap #(
   parameter int ROW    = 12,
   parameter int ADDR_W = 4,
   parameter int INC_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [INC_W-1:0]  inc,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_val,
   output logic [ADDR_W-1:0] ptr
);

   localparam int SUM_W = ((ADDR_W > INC_W) ? ADDR_W : INC_W) + 2;
   localparam logic [SUM_W-1:0] ROW_S = SUM_W'(ROW);

   logic [SUM_W-1:0] sum;
   logic [SUM_W-1:0] once;
   logic [SUM_W-1:0] twice;
   logic [ADDR_W-1:0] ptr_next;

   // inc can reach about 2*ROW, so two conditional subtractions cover every case.
   always_comb begin
      sum      = SUM_W'(ptr) + SUM_W'(inc);
      once     = (sum >= ROW_S) ? (sum - ROW_S) : sum;
      twice    = (once >= ROW_S) ? (once - ROW_S) : once;
      ptr_next = ptr;
      if (load) begin
         ptr_next = load_val;
      end else if (en) begin
         ptr_next = ADDR_W'(twice);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else begin
         ptr <= ptr_next;
      end
   end

endmodule

// File: rtl/ifmap_spad_fill_ctrl.sv
// Streams row_len words from the IFMap buffer into a circular scratchpad,
// writing only into slots the PE datapath has released.
module ifmap_spad_fill_ctrl
   import ifmap_spad_fill_ctrl_pkg::*;
#(
   parameter int IFMAP_SPAD_WIDTH = 16,
   parameter int IFMAP_SPAD_ROW   = 12,
   parameter int LEN_W            = 8,
   localparam int ADDR_W = addr_width(IFMAP_SPAD_ROW),
   localparam int CNT_W  = cnt_width(IFMAP_SPAD_ROW)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [LEN_W-1:0]            row_len,
   input  logic [IFMAP_SPAD_WIDTH-1:0] buf_dout,
   input  logic                        buf_empty,
   output logic                        buf_ren,
   output logic [IFMAP_SPAD_WIDTH-1:0] spad_din,
   output logic [ADDR_W-1:0]           spad_waddr,
   output logic                        spad_wen,
   input  logic                        rel,
   input  logic [CNT_W-1:0]            rel_num,
   output logic [ADDR_W-1:0]           rd_base,
   output logic [CNT_W-1:0]            occupancy,
   output logic                        full,
   output logic                        busy,
   output logic                        done
);

   localparam logic [CNT_W:0]  ROW_C    = (CNT_W+1)'(IFMAP_SPAD_ROW);
   localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(IFMAP_SPAD_ROW - 1);

   fill_state_t       state;
   fill_state_t       state_next;
   logic [LEN_W-1:0]  remaining;
   logic              inflight;
   logic              issue;
   logic [CNT_W:0]    committed;
   logic              over_release;
   logic [ADDR_W-1:0] wptr;
   logic [ADDR_W-1:0] wptr_after;

   // Words already requested from the buffer count against free space.
   assign committed    = {1'b0, occupancy} + (CNT_W+1)'(inflight);
   assign issue        = (state == FILL) && (remaining != '0) && !buf_empty
                         && (committed < ROW_C);
   assign over_release = rel && ({1'b0, rel_num} > committed);

   assign buf_ren    = issue;
   assign spad_wen   = inflight;
   assign spad_din   = buf_dout;
   assign spad_waddr = wptr;
   assign busy       = (state != IDLE);
   assign done       = (state == DONE);
   assign full       = (occupancy == CNT_W'(IFMAP_SPAD_ROW));

   // Where the write pointer lands after this cycle's write; an over-release
   // snaps the read base there so the store reads as empty.
   assign wptr_after = !spad_wen ? wptr : ((wptr == LAST_A) ? '0 : wptr + ADDR_W'(1));

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (start) state_next = (row_len == '0) ? DONE : FILL;
         FILL:    if (remaining == '0) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // The final write is still in flight when remaining hits zero, so done
   // lands exactly one cycle after it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         remaining <= '0;
         inflight  <= 1'b0;
         occupancy <= '0;
      end else begin
         state    <= state_next;
         inflight <= issue;
         if ((state == IDLE) && start) begin
            remaining <= row_len;
         end else if (issue) begin
            remaining <= remaining - LEN_W'(1);
         end
         if (over_release) begin
            occupancy <= '0;
         end else if (rel) begin
            occupancy <= CNT_W'(committed - {1'b0, rel_num});
         end else begin
            occupancy <= CNT_W'(committed);
         end
      end
   end

   spad_ptr_wrap #(
      .ROW    (IFMAP_SPAD_ROW),
      .ADDR_W (ADDR_W),
      .INC_W  (1)
   ) u_wptr (
      .clk      (clk),
      .rst      (rst),
      .en       (spad_wen),
      .inc      (1'b1),
      .load     (1'b0),
      .load_val ('0),
      .ptr      (wptr)
   );

   spad_ptr_wrap #(
      .ROW    (IFMAP_SPAD_ROW),
      .ADDR_W (ADDR_W),
      .INC_W  (CNT_W)
   ) u_rd_base (
      .clk      (clk),
      .rst      (rst),
      .en       (rel),
      .inc      (rel_num),
      .load     (over_release),
      .load_val (wptr_after),
      .ptr      (rd_base)
   );

endmodule
